// File: rtl/mod2nm1_pkg.sv
// Shared types and helpers for the modulo-(2^n - 1) residue family.
package mod2nm1_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FOLD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Widest residue word the helpers below can carry.
    localparam int MAX_W = 64;

    // Single-zero negation: callers zero-extend the residue and truncate the
    // result back to their width, so 0 maps to 0 and never to all-ones.
    function automatic logic [MAX_W-1:0] neg_s0(input logic [MAX_W-1:0] x);
        logic [MAX_W-1:0] r_s;
        if (x == {MAX_W{1'b0}}) begin
            r_s = {MAX_W{1'b0}};
        end else begin
            r_s = ~x;
        end
        return r_s;
    endfunction

endpackage

// File: rtl/mod_2nm1_reduce_add.sv
// End-around-carry adder modulo 2^width - 1 with single-zero output.
// speed selects the carry-prefix network: 0 ripple, 1 Brent-Kung, 2 Sklansky.
module AddMod2Nm1s0 #(
    parameter int width = 8,
    parameter int speed = 2
) (
    input  logic [width-1:0] a_i,
    input  logic [width-1:0] b_i,
    output logic [width-1:0] sum_o
);

    localparam int LOG_W = (width > 1) ? $clog2(width) : 1;

    logic [width-1:0] gen_s;
    logic [width-1:0] prop_s;
    logic [width-1:0] grp_g_s;
    logic [width-1:0] grp_p_s;
    logic [width-1:0] raw_sum_s;
    logic             cin_s;
    logic             zero_s;

    assign gen_s  = a_i & b_i;
    assign prop_s = a_i ^ b_i;

    // Group generate/propagate over bits [0..i] for every i.
    always_comb begin : prefix_net
        logic [width-1:0] g_v;
        logic [width-1:0] p_v;
        int src;
        g_v = gen_s;
        p_v = prop_s;
        if (speed == 0) begin
            for (int i = 1; i < width; i++) begin
                g_v[i] = g_v[i] | (p_v[i] & g_v[i-1]);
                p_v[i] = p_v[i] & p_v[i-1];
            end
        end else if (speed == 1) begin
            for (int l = 0; l < LOG_W; l++) begin
                for (int i = (2 << l) - 1; i < width; i += (2 << l)) begin
                    src    = i - (1 << l);
                    g_v[i] = g_v[i] | (p_v[i] & g_v[src]);
                    p_v[i] = p_v[i] & p_v[src];
                end
            end
            for (int l = LOG_W - 1; l >= 0; l--) begin
                for (int i = 3 * (1 << l) - 1; i < width; i += (2 << l)) begin
                    src    = i - (1 << l);
                    g_v[i] = g_v[i] | (p_v[i] & g_v[src]);
                    p_v[i] = p_v[i] & p_v[src];
                end
            end
        end else begin
            for (int l = 0; l < LOG_W; l++) begin
                for (int i = 0; i < width; i++) begin
                    if (((i >> l) & 1) == 1) begin
                        src    = ((i >> l) << l) - 1;
                        g_v[i] = g_v[i] | (p_v[i] & g_v[src]);
                        p_v[i] = p_v[i] & p_v[src];
                    end else begin
                        src = i;
                    end
                end
            end
        end
        grp_g_s = g_v;
        grp_p_s = p_v;
    end

    // The carry out of the top bit re-enters at bit 0 (end-around carry).
    assign cin_s = grp_g_s[width-1];

    // Sum bits using the prefix carries with the end-around carry-in.
    always_comb begin : sum_bits
        logic c_v;
        raw_sum_s = '0;
        for (int i = 0; i < width; i++) begin
            if (i == 0) begin
                c_v = cin_s;
            end else begin
                c_v = grp_g_s[i-1] | (grp_p_s[i-1] & cin_s);
            end
            raw_sum_s[i] = prop_s[i] ^ c_v;
        end
    end

    // All-ones appears only for a+b = 2^n-1 or a=b=all-ones; both mean zero.
    assign zero_s = grp_p_s[width-1] | (&gen_s);
    assign sum_o  = zero_s ? {width{1'b0}} : raw_sum_s;

endmodule

// File: rtl/mod_2nm1_reduce.sv
// Sequential binary-to-residue reducer: folds one width-bit chunk per cycle
// into an accumulator modulo 2^width - 1, optionally negating the result.
module mod_2nm1_reduce
    import mod2nm1_pkg::*;
#(
    parameter int width  = 8,
    parameter int chunks = 4,
    parameter int speed  = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [chunks*width-1:0] in_data_i,
    input  logic                    in_neg_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [width-1:0]        out_res_o,
    output logic                    busy_o
);

    localparam int CNT_W  = (chunks > 1) ? $clog2(chunks) : 1;
    localparam int DATA_W = chunks * width;

    state_t              state_r;
    logic [width-1:0]    acc_r;
    logic [width-1:0]    res_r;
    logic [DATA_W-1:0]   shreg_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                neg_r;
    logic [width-1:0]    sum_s;
    logic [width-1:0]    fold_res_s;
    logic                last_s;

    AddMod2Nm1s0 #(
        .width (width),
        .speed (speed)
    ) u_add (
        .a_i   (acc_r),
        .b_i   (shreg_r[width-1:0]),
        .sum_o (sum_s)
    );

    assign last_s = (cnt_r == CNT_W'(chunks - 1));

    // Final residue as it will be latched on the last fold.
    always_comb begin
        fold_res_s = sum_s;
        if (neg_r) begin
            fold_res_s = width'(neg_s0(MAX_W'(sum_s)));
        end else begin
            fold_res_s = sum_s;
        end
    end

    // Control FSM with accumulator, shift register and result register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            acc_r   <= '0;
            res_r   <= '0;
            shreg_r <= '0;
            cnt_r   <= '0;
            neg_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        shreg_r <= in_data_i;
                        neg_r   <= in_neg_i;
                        acc_r   <= '0;
                        cnt_r   <= '0;
                        state_r <= ST_FOLD;
                    end
                end
                ST_FOLD: begin
                    acc_r   <= sum_s;
                    shreg_r <= shreg_r >> width;
                    cnt_r   <= cnt_r + CNT_W'(1);
                    if (last_s) begin
                        res_r   <= fold_res_s;
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready_i) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = (state_r == ST_IDLE);
    assign out_valid_o = (state_r == ST_DONE);
    assign busy_o      = (state_r != ST_IDLE);
    assign out_res_o   = res_r;

endmodule

// File: tb/tb_mod_2nm1_reduce.sv
// Self-checking bench for mod_2nm1_reduce (width=8, chunks=4).
module tb_mod_2nm1_reduce;

    localparam int W = 8;
    localparam int C = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [C*W-1:0] in_data;
    logic           in_neg;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_res;
    logic           busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] exp_q[$];
    logic         prev_hold;
    logic [W-1:0] prev_res;

    mod_2nm1_reduce #(.width(W), .chunks(C), .speed(2)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_neg_i    (in_neg),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_res_o   (out_res),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    // Reference: plain modular arithmetic, zero for multiples, negated on request.
    function automatic logic [W-1:0] model(input logic [C*W-1:0] x, input logic ng);
        longint unsigned m;
        longint unsigned r;
        m = (64'd1 << W) - 64'd1;
        r = longint'(x) % m;
        if (ng && r != 0) r = m - r;
        return W'(r);
    endfunction

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Scoreboard and stability monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_res", {24'd0, out_res}, {24'd0, prev_res});
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_data, in_neg));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_valid: got res %h with no operand pending", out_res);
                end else begin
                    check("result", {24'd0, out_res}, {24'd0, exp_q[0]});
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_res  = out_res;
        end
    end

    // Offer one operand once the block is ready; called at posedge+1.
    task automatic send(input logic [C*W-1:0] x, input logic ng, input bit rnd);
        int t;
        t = 0;
        while (!in_ready && t < 64) begin
            @(posedge clk); #1;
            if (rnd) out_ready = ($urandom_range(0, 2) != 0);
            t++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: in_ready stayed %b, required 1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = x;
        in_neg   = ng;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (rnd) out_ready = ($urandom_range(0, 2) != 0);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < C + 3) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic directed(input logic [C*W-1:0] x, input logic ng, input logic [W-1:0] exp);
        int lat;
        out_ready = 1'b1;
        send(x, ng, 1'b0);
        wait_valid(lat);
        check("latency", lat, C);
        check("directed_res", {24'd0, out_res}, {24'd0, exp});
        @(posedge clk); #1;
        check("back_to_idle", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        logic [C*W-1:0] x;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_neg    = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_res", {24'd0, out_res}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("pin_a", {24'd0, model(32'h01020304, 1'b0)}, 32'h0A);
        check("pin_b", {24'd0, model(32'h01020304, 1'b1)}, 32'hF5);
        check("pin_c", {24'd0, model(32'hFFFFFFFF, 1'b0)}, 32'h00);
        check("pin_d", {24'd0, model(32'h00000000, 1'b1)}, 32'h00);
        check("pin_e", {24'd0, model(32'h80808080, 1'b0)}, 32'h02);

        directed(32'h01020304, 1'b0, 8'h0A);
        directed(32'hFFFFFFFF, 1'b0, 8'h00);
        directed(32'h000000FF, 1'b0, 8'h00);
        directed(32'h80808080, 1'b0, 8'h02);
        directed(32'h01020304, 1'b1, 8'hF5);
        directed(32'h00000000, 1'b1, 8'h00);
        directed(32'hFEFEFEFE, 1'b1, 8'h04);

        // Backpressure: result held, new operands refused.
        out_ready = 1'b0;
        send(32'h01020304, 1'b0, 1'b0);
        wait_valid(lat);
        check("bp_latency", lat, C);
        repeat (5) begin
            in_valid = 1'b1;
            in_data  = 32'hDEADBEEF;
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_res", {24'd0, out_res}, 32'h0A);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);

        // Reset during the second fold cycle.
        send(32'h12345678, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_fold_busy", {31'd0, busy}, 32'd0);
        check("rst_fold_ready", {31'd0, in_ready}, 32'd1);
        check("rst_fold_valid", {31'd0, out_valid}, 32'd0);
        check("rst_fold_res", {24'd0, out_res}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        directed(32'h00000005, 1'b0, 8'h05);

        // Reset while a result waits in DONE.
        out_ready = 1'b0;
        send(32'h01020304, 1'b1, 1'b0);
        wait_valid(lat);
        rst = 1'b1;
        #1;
        check("rst_done_valid", {31'd0, out_valid}, 32'd0);
        check("rst_done_res", {24'd0, out_res}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;

        // Random regression with consumer stalls.
        for (int i = 0; i < 3000; i++) begin
            x = $urandom;
            if (i % 7 == 0) x[7:0] = 8'hFF;
            if (i % 11 == 0) x = 32'hFFFFFFFF;
            if (i % 13 == 0) x = 32'h00000000;
            send(x, 1'($urandom_range(0, 1)), 1'b1);
        end
        out_ready = 1'b1;
        lat = 0;
        while ((exp_q.size() != 0 || !in_ready) && lat < 32) begin
            @(posedge clk); #1;
            lat++;
        end
        check("drain_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
